// File: rtl/fix_seq_tracker.sv
// fix_seq_tracker: per-session FIX MsgSeqNum tracking.
// Keeps one outgoing counter and one expected-incoming counter per session.
// Incoming sequence numbers are classified as accept, gap, duplicate or too-low.
// On a gap, the tracker reports the range of missing numbers for a resend request.
// Optional feature macro: FIX_SEQ_RESET_EN enables SequenceReset (reset mode) handling.
module fix_seq_tracker #(
  parameter int unsigned NUM_SESSIONS = 4,
  parameter int unsigned SEQ_W        = 16,
  localparam int unsigned SESS_W      = (NUM_SESSIONS > 1) ? $clog2(NUM_SESSIONS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              connect_i,
  input  logic [SESS_W-1:0] conn_sess_i,
  input  logic              tx_send_i,
  input  logic [SESS_W-1:0] tx_sess_i,
  output logic [SEQ_W-1:0]  outgoing_seq_num_o,
  input  logic              rx_valid_i,
  input  logic [SESS_W-1:0] rx_sess_i,
  input  logic [SEQ_W-1:0]  rx_seq_i,
  input  logic              rx_possdup_i,
  input  logic              rx_ignore_i,
  input  logic              rx_seqrst_i,
  input  logic [SEQ_W-1:0]  rx_newseq_i,
  output logic [SEQ_W-1:0]  expected_seq_num_o,
  output logic              rx_res_valid_o,
  output logic [SESS_W-1:0] rx_res_sess_o,
  output logic [2:0]        rx_res_code_o,
  output logic [SEQ_W-1:0]  resend_begin_o,
  output logic [SEQ_W-1:0]  resend_end_o,
  output logic              overflow_o
);

  localparam logic [2:0] CODE_ACCEPT  = 3'd0;
  localparam logic [2:0] CODE_GAP     = 3'd1;
  localparam logic [2:0] CODE_DUP     = 3'd2;
  localparam logic [2:0] CODE_LOW     = 3'd3;
`ifdef FIX_SEQ_RESET_EN
  localparam logic [2:0] CODE_SRST_OK = 3'd4;
  localparam logic [2:0] CODE_SRST_NO = 3'd5;
`endif

  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);
  localparam logic [SEQ_W-1:0] SEQ_MAX = {SEQ_W{1'b1}};

  logic [SEQ_W-1:0]  r_out [NUM_SESSIONS];
  logic [SEQ_W-1:0]  r_exp [NUM_SESSIONS];
  logic [SEQ_W-1:0]  w_out_nxt [NUM_SESSIONS];
  logic [SEQ_W-1:0]  w_exp_nxt [NUM_SESSIONS];

  logic [SEQ_W-1:0]  w_tx_cur;
  logic [SEQ_W-1:0]  w_rx_cur;
  logic              w_rx_hit;
  logic              w_rx_fire;
  logic              w_exp_wr;
  logic [SEQ_W-1:0]  w_exp_val;
  logic [2:0]        w_code;
  logic [SEQ_W-1:0]  w_rs_begin;
  logic [SEQ_W-1:0]  w_rs_end;
  logic              w_ovf_hit;

  logic              r_res_valid;
  logic [SESS_W-1:0] r_res_sess;
  logic [2:0]        r_res_code;
  logic [SEQ_W-1:0]  r_rs_begin;
  logic [SEQ_W-1:0]  r_rs_end;
  logic              r_ovf;

`ifndef FIX_SEQ_RESET_EN
  // SequenceReset inputs have no function when the feature is compiled out
  logic w_unused_seqrst;
  assign w_unused_seqrst = ^{rx_seqrst_i, rx_newseq_i};
`endif

  // Counter read muxes; an out-of-range index reads zero and marks no hit
  always_comb begin
    w_tx_cur = '0;
    w_rx_cur = '0;
    w_rx_hit = 1'b0;
    for (int s = 0; s < NUM_SESSIONS; s++) begin
      if (tx_sess_i == SESS_W'(s)) begin
        w_tx_cur = r_out[s];
      end
      if (rx_sess_i == SESS_W'(s)) begin
        w_rx_cur = r_exp[s];
        w_rx_hit = 1'b1;
      end
    end
  end

  // Classify the received message against the expected counter
  always_comb begin
    w_rx_fire  = rx_valid_i & ~rx_ignore_i & w_rx_hit;
    w_exp_wr   = 1'b0;
    w_exp_val  = w_rx_cur;
    w_code     = CODE_ACCEPT;
    w_rs_begin = '0;
    w_rs_end   = '0;
`ifdef FIX_SEQ_RESET_EN
    if (rx_seqrst_i) begin
      if (rx_newseq_i > w_rx_cur) begin
        w_exp_wr  = 1'b1;
        w_exp_val = rx_newseq_i;
        w_code    = CODE_SRST_OK;
      end else begin
        w_code    = CODE_SRST_NO;
      end
    end else
`endif
    if (rx_seq_i == w_rx_cur) begin
      w_exp_wr  = 1'b1;
      w_exp_val = (w_rx_cur == SEQ_MAX) ? SEQ_MAX : w_rx_cur + SEQ_ONE;
      w_code    = CODE_ACCEPT;
    end else if (rx_seq_i > w_rx_cur) begin
      w_code     = CODE_GAP;
      w_rs_begin = w_rx_cur;
      w_rs_end   = rx_seq_i - SEQ_ONE;
    end else if (rx_possdup_i) begin
      w_code = CODE_DUP;
    end else begin
      w_code = CODE_LOW;
    end
  end

  // Next counter values; a logon on a session overrides its tx/rx updates
  always_comb begin
    w_out_nxt = r_out;
    w_exp_nxt = r_exp;
    w_ovf_hit = 1'b0;
    for (int s = 0; s < NUM_SESSIONS; s++) begin
      if (tx_send_i && (tx_sess_i == SESS_W'(s)) && (r_out[s] != SEQ_MAX)) begin
        w_out_nxt[s] = r_out[s] + SEQ_ONE;
      end
      if (w_rx_fire && w_exp_wr && (rx_sess_i == SESS_W'(s))) begin
        w_exp_nxt[s] = w_exp_val;
      end
      if (connect_i && (conn_sess_i == SESS_W'(s))) begin
        w_out_nxt[s] = SEQ_ONE;
        w_exp_nxt[s] = SEQ_ONE;
      end
      if ((w_out_nxt[s] == SEQ_MAX) || (w_exp_nxt[s] == SEQ_MAX)) begin
        w_ovf_hit = 1'b1;
      end
    end
  end

  // Counters, registered result and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SESSIONS; s++) begin
        r_out[s] <= SEQ_ONE;
        r_exp[s] <= SEQ_ONE;
      end
      r_res_valid <= 1'b0;
      r_res_sess  <= '0;
      r_res_code  <= '0;
      r_rs_begin  <= '0;
      r_rs_end    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_out       <= w_out_nxt;
      r_exp       <= w_exp_nxt;
      r_res_valid <= w_rx_fire;
      r_res_sess  <= rx_sess_i;
      r_res_code  <= w_code;
      r_rs_begin  <= w_rs_begin;
      r_rs_end    <= w_rs_end;
      r_ovf       <= r_ovf | w_ovf_hit;
    end
  end

  assign outgoing_seq_num_o = w_tx_cur;
  assign expected_seq_num_o = w_rx_cur;
  assign rx_res_valid_o     = r_res_valid;
  assign rx_res_sess_o      = r_res_sess;
  assign rx_res_code_o      = r_res_code;
  assign resend_begin_o     = r_rs_begin;
  assign resend_end_o       = r_rs_end;
  assign overflow_o         = r_ovf;

endmodule
